// File: rtl/downcounter_pkg.sv
// Shared types and defaults for the downcounter block.
// Auto-reload behaviour is selected with the DOWNCOUNTER_AUTORELOAD_EN macro.
package downcounter_pkg;

  localparam int COUNT_BITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/downcounter.sv
// Loadable down-counter with IDLE/RUN/DONE control and a one-cycle min_tick at zero.
// Define DOWNCOUNTER_AUTORELOAD_EN to restart from the last load value when enabled in DONE.
module downcounter
  import downcounter_pkg::*;
#(
  parameter int COUNT_BITS = COUNT_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [COUNT_BITS-1:0] load_value,
  input  logic                  enable,
  output logic [COUNT_BITS-1:0] count,
  output logic                  min_tick,
  output logic                  busy,
  output logic                  done
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [COUNT_BITS-1:0] r_count;
  logic [COUNT_BITS-1:0] w_count_nxt;
  logic [COUNT_BITS-1:0] r_reload;
  logic [COUNT_BITS-1:0] w_reload_nxt;
  logic                  r_tick;
  logic                  w_tick_nxt;

  // Load beats enable in every state; a zero load value goes straight to DONE with a tick.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_tick_nxt   = 1'b0;
    if (load) begin
      w_count_nxt  = load_value;
      w_reload_nxt = load_value;
      if (load_value != '0) begin
        w_state_nxt = ST_RUN;
      end else begin
        w_state_nxt = ST_DONE;
        w_tick_nxt  = 1'b1;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (enable) begin
            if (r_count > COUNT_BITS'(1)) begin
              w_count_nxt = r_count - COUNT_BITS'(1);
            end else begin
              w_count_nxt = '0;
              w_state_nxt = ST_DONE;
              w_tick_nxt  = 1'b1;
            end
          end
        end
        ST_DONE: begin
`ifdef DOWNCOUNTER_AUTORELOAD_EN
          if (enable) begin
            if (r_reload != '0) begin
              w_count_nxt = r_reload;
              w_state_nxt = ST_RUN;
            end else begin
              w_tick_nxt = 1'b1;
            end
          end
`else
          w_count_nxt = '0;
`endif
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_tick   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_tick   <= w_tick_nxt;
    end
  end

  assign count    = r_count;
  assign min_tick = r_tick;
  assign busy     = (r_state == ST_RUN);
  assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_downcounter.sv
// Directed bench for downcounter at COUNT_BITS=2; expected {count,min_tick,busy,done}
// is queued as each cycle is driven and compared one edge later.
module tb_downcounter;

  localparam int CB = 2;
  localparam int W  = CB + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [CB-1:0] load_value;
  logic          enable;
  logic [CB-1:0] count;
  logic          min_tick;
  logic          busy;
  logic          done;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;

  downcounter #(.COUNT_BITS(CB)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .count      (count),
    .min_tick   (min_tick),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Drive one cycle from a negedge, queue its expectation, then check at the next negedge.
  task automatic step(input logic rst, input logic ld, input logic [CB-1:0] lv,
                      input logic en, input logic [CB-1:0] e_cnt, input logic e_tick,
                      input logic e_busy, input logic e_done, input string tag);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    string        t;
    reset      = rst;
    load       = ld;
    load_value = lv;
    enable     = en;
    exp_q.push_back({e_cnt, e_tick, e_busy, e_done});
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    got = {count, min_tick, busy, done};
    exp = exp_q.pop_front();
    t   = tag_q.pop_front();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got cnt/tick/busy/done=%b exp=%b", t, got, exp);
    end
  endtask

  initial begin
    int v;
    reset      = 1'b1;
    load       = 1'b0;
    load_value = '0;
    enable     = 1'b0;
    @(negedge clk);

    // Reset overrides load and enable.
    step(1, 1, 2'd3, 1, 2'd0, 0, 0, 0, "rst_hold0");
    step(1, 1, 2'd3, 1, 2'd0, 0, 0, 0, "rst_hold1");
    step(0, 0, 2'd0, 1, 2'd0, 0, 0, 0, "idle_ignores_en");

    // Straight countdown from 3.
    step(0, 1, 2'd3, 0, 2'd3, 0, 1, 0, "cd_load3");
    step(0, 0, 2'd0, 1, 2'd2, 0, 1, 0, "cd_2");
    step(0, 0, 2'd0, 1, 2'd1, 0, 1, 0, "cd_1");
    step(0, 0, 2'd0, 1, 2'd0, 1, 0, 1, "cd_0_tick");
`ifndef DOWNCOUNTER_AUTORELOAD_EN
    for (int i = 0; i < 4; i++) step(0, 0, 2'd0, 1, 2'd0, 0, 0, 1, "done_terminal");
`else
    for (int i = 0; i < 4; i++) step(0, 0, 2'd0, 0, 2'd0, 0, 0, 1, "done_hold");
`endif

    // Gapped enable.
    step(0, 1, 2'd3, 0, 2'd3, 0, 1, 0, "gap_load3");
    step(0, 0, 2'd0, 1, 2'd2, 0, 1, 0, "gap_en1");
    step(0, 0, 2'd0, 0, 2'd2, 0, 1, 0, "gap_en0a");
    step(0, 0, 2'd0, 0, 2'd2, 0, 1, 0, "gap_en0b");
    step(0, 0, 2'd0, 1, 2'd1, 0, 1, 0, "gap_en1b");
    step(0, 0, 2'd0, 1, 2'd0, 1, 0, 1, "gap_zero");

    // Load wins over the final decrement.
    step(0, 1, 2'd3, 0, 2'd3, 0, 1, 0, "race_load3");
    step(0, 0, 2'd0, 1, 2'd2, 0, 1, 0, "race_2");
    step(0, 0, 2'd0, 1, 2'd1, 0, 1, 0, "race_1");
    step(0, 1, 2'd2, 1, 2'd2, 0, 1, 0, "race_reload2");
    step(0, 0, 2'd0, 1, 2'd1, 0, 1, 0, "race_after1");
    step(0, 0, 2'd0, 1, 2'd0, 1, 0, 1, "race_after0");

    // Zero load, then reset mid-countdown.
    step(0, 1, 2'd0, 0, 2'd0, 1, 0, 1, "load0_tick");
    step(0, 0, 2'd0, 0, 2'd0, 0, 0, 1, "load0_tick_off");
    step(0, 1, 2'd3, 0, 2'd3, 0, 1, 0, "abort_load3");
    step(0, 0, 2'd0, 1, 2'd2, 0, 1, 0, "abort_2");
    step(1, 0, 2'd0, 1, 2'd0, 0, 0, 0, "abort_reset");
    step(0, 0, 2'd0, 1, 2'd0, 0, 0, 0, "abort_idle");

    // Random load values with continuous enable.
    for (int n = 0; n < 6; n++) begin
      v = $urandom_range(1, 3);
      step(0, 1, CB'(v), 0, CB'(v), 0, 1, 0, "rnd_load");
      for (int k = v - 1; k >= 0; k--)
        step(0, 0, 2'd0, 1, CB'(k), (k == 0), (k != 0), (k == 0), "rnd_count");
    end

`ifdef DOWNCOUNTER_AUTORELOAD_EN
    step(0, 1, 2'd2, 0, 2'd2, 0, 1, 0, "ar_load2");
    step(0, 0, 2'd0, 1, 2'd1, 0, 1, 0, "ar_1");
    step(0, 0, 2'd0, 1, 2'd0, 1, 0, 1, "ar_0");
    step(0, 0, 2'd0, 1, 2'd2, 0, 1, 0, "ar_reload");
    step(0, 0, 2'd0, 1, 2'd1, 0, 1, 0, "ar_1b");
    step(0, 0, 2'd0, 1, 2'd0, 1, 0, 1, "ar_0b");
    step(0, 0, 2'd0, 0, 2'd0, 0, 0, 1, "ar_hold");
    step(0, 1, 2'd0, 0, 2'd0, 1, 0, 1, "ar_zero_load");
    step(0, 0, 2'd0, 1, 2'd0, 1, 0, 1, "ar_zero_tick1");
    step(0, 0, 2'd0, 1, 2'd0, 1, 0, 1, "ar_zero_tick2");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
